// File: rtl/relu_fmap_collector.sv
// relu_fmap_collector
// Collects a stream of feature-map elements (optional ReLU on each) into a
// flattened register and presents the complete map to the pooling stage.
// The map is held frozen until the downstream stage accepts it.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-high reset
//   in_valid   - in_data carries an element
//   in_ready   - collector accepts an element this cycle (decoded from state)
//   in_data    - element in stream order, k = (d*InputH + r)*InputW + c
//   out_valid  - fmap_out holds a complete map
//   out_ready  - downstream accepts the map this cycle
//   fmap_out   - flattened map, element k at fmap_out[k*DATA_WIDTH +: DATA_WIDTH]
//   frame_done - one-cycle pulse after the last element of a frame is written
module relu_fmap_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned InputH     = 28,
  parameter int unsigned InputW     = 28,
  parameter int unsigned Depth      = 1,
  parameter int unsigned RELU       = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [DATA_WIDTH-1:0]                        in_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [0:InputH*InputW*Depth*DATA_WIDTH-1]    fmap_out,
  output logic                                         frame_done
);

  localparam int unsigned N     = InputH * InputW * Depth;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MAP_W = N * DATA_WIDTH;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [0:MAP_W-1]      r_fmap;
  logic                  r_out_valid;
  logic                  r_frame_done;
  logic                  w_we;
  logic                  w_out_valid_nxt;
  logic                  w_frame_done_nxt;
  logic [DATA_WIDTH-1:0] w_elem;

  // ReLU keyed on the MSB only, so it works for signed fixed-point and half-float (-0 -> +0)
  always_comb begin
    w_elem = in_data;
    if ((RELU != 0) && in_data[DATA_WIDTH-1]) begin
      w_elem = '0;
    end
  end

  // Next-state, counter and write-enable decode
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_we             = 1'b0;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_FILL: begin
        if (in_valid) begin
          w_we = 1'b1;
          if (r_cnt == CNT_W'(N - 1)) begin
            w_cnt_nxt        = '0;
            w_state_nxt      = S_HOLD;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
    w_out_valid_nxt = (w_state_nxt == S_HOLD);
  end

  // State, counter and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FILL;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Map storage: slots are only overwritten in order, never cleared except by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fmap <= '0;
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (w_we && (r_cnt == CNT_W'(k))) begin
          r_fmap[k*DATA_WIDTH +: DATA_WIDTH] <= w_elem;
        end
      end
    end
  end

  assign in_ready   = (r_state == S_FILL);
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign fmap_out   = r_fmap;

endmodule

// File: tb/tb_relu_fmap_collector.sv
// Bench for relu_fmap_collector: two instances (4x4x1 with ReLU, 2x2x2 without),
// a stream-level reference model per instance checked every cycle, plus
// directed literal expectations.
module tb_relu_fmap_collector;

  localparam int NA = 16;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic            in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [15:0]     in_data_a = '0;
  logic            in_ready_a, out_valid_a, frame_done_a;
  logic [0:NA*16-1] fmap_a;

  logic            in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [15:0]     in_data_b = '0;
  logic            in_ready_b, out_valid_b, frame_done_b;
  logic [0:NB*16-1] fmap_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  relu_fmap_collector #(.DATA_WIDTH(16), .InputH(4), .InputW(4), .Depth(1), .RELU(1)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .fmap_out(fmap_a), .frame_done(frame_done_a)
  );

  relu_fmap_collector #(.DATA_WIDTH(16), .InputH(2), .InputW(2), .Depth(2), .RELU(0)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .fmap_out(fmap_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] relu_f(input logic [15:0] x, input bit en);
    return (en && x[15]) ? 16'h0000 : x;
  endfunction

  // Reference model: frame = N accepted beats, then a held map until accepted
  logic [15:0] mem_a [NA] = '{default: 16'h0};
  logic [15:0] mem_b [NB] = '{default: 16'h0};
  int  cnt_a = 0, cnt_b = 0;
  bit  hold_a = 0, hold_b = 0, done_a = 0, done_b = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (mem_a[k]) mem_a[k] = 16'h0;
      foreach (mem_b[k]) mem_b[k] = 16'h0;
      cnt_a = 0; cnt_b = 0; hold_a = 0; hold_b = 0; done_a = 0; done_b = 0;
    end else begin
      done_a = 0;
      if (hold_a) begin
        if (out_ready_a) hold_a = 0;
      end else if (in_valid_a) begin
        mem_a[cnt_a] = relu_f(in_data_a, 1'b1);
        cnt_a++;
        if (cnt_a == NA) begin cnt_a = 0; hold_a = 1; done_a = 1; end
      end
      done_b = 0;
      if (hold_b) begin
        if (out_ready_b) hold_b = 0;
      end else if (in_valid_b) begin
        mem_b[cnt_b] = relu_f(in_data_b, 1'b0);
        cnt_b++;
        if (cnt_b == NB) begin cnt_b = 0; hold_b = 1; done_b = 1; end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    int nb;
    chk("a in_ready", 64'(in_ready_a), 64'(!hold_a));
    chk("a out_valid", 64'(out_valid_a), 64'(hold_a));
    chk("a frame_done", 64'(frame_done_a), 64'(done_a));
    nb = 0;
    for (int k = 0; k < NA; k++) if (fmap_a[k*16 +: 16] !== mem_a[k]) nb++;
    chk("a fmap slots differing", 64'(nb), 64'(0));
    chk("b in_ready", 64'(in_ready_b), 64'(!hold_b));
    chk("b out_valid", 64'(out_valid_b), 64'(hold_b));
    chk("b frame_done", 64'(frame_done_b), 64'(done_b));
    nb = 0;
    for (int k = 0; k < NB; k++) if (fmap_b[k*16 +: 16] !== mem_b[k]) nb++;
    chk("b fmap slots differing", 64'(nb), 64'(0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one element and hold it until a handshake edge has passed
  task automatic send(input bit b, input logic [15:0] d, input int gap);
    int n;
    bit ok;
    if (gap > 0) begin
      if (b) in_valid_b = 1'b0; else in_valid_a = 1'b0;
      repeat (gap) tick();
    end
    if (b) begin in_valid_b = 1'b1; in_data_b = d; end
    else   begin in_valid_a = 1'b1; in_data_a = d; end
    n = 0;
    do begin
      ok = b ? in_ready_b : in_ready_a;
      tick();
      n++;
    end while (!ok && n < 40);
    if (!ok) chk("send timeout waiting for in_ready", 64'(ok), 64'(1));
  endtask

  initial begin
    int c1, c2;
    logic [15:0] relu_in [4];
    relu_in[0] = 16'h8000; relu_in[1] = 16'hFFFF; relu_in[2] = 16'h7FFF; relu_in[3] = 16'h0000;

    // Power-up reset
    #1 reset = 1'b1;
    #1;
    chk("reset in_ready", 64'(in_ready_a), 64'(1));
    chk("reset out_valid", 64'(out_valid_a), 64'(0));
    chk("reset fmap zero", 64'(fmap_a == '0), 64'(1));
    repeat (2) tick();
    reset = 1'b0;

    // Full frame, back-to-back, out_ready low
    for (int i = 1; i <= 16; i++) begin
      send(1'b0, 16'(i), 0);
      chk("a out_valid during fill", 64'(out_valid_a), 64'(i == 16));
    end
    chk("a frame_done after last beat", 64'(frame_done_a), 64'(1));
    chk("a slot0", 64'(fmap_a[0 +: 16]), 64'h0001);
    chk("a slot15", 64'(fmap_a[240 +: 16]), 64'h0010);
    in_data_a = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a in_ready in hold", 64'(in_ready_a), 64'(0));
      chk("a out_valid held", 64'(out_valid_a), 64'(1));
      chk("a frame_done single pulse", 64'(frame_done_a), 64'(0));
    end
    out_ready_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    chk("a out_valid drops after accept", 64'(out_valid_a), 64'(0));
    chk("a in_ready back in fill", 64'(in_ready_a), 64'(1));
    chk("a slot0 not DEAD", 64'(fmap_a[0 +: 16]), 64'h0001);

    // ReLU boundary, then rest of the frame with random gaps
    for (int i = 0; i < 4; i++) send(1'b0, relu_in[i], 0);
    in_valid_a = 1'b0;
    chk("a relu 8000", 64'(fmap_a[0 +: 16]), 64'h0000);
    chk("a relu FFFF", 64'(fmap_a[16 +: 16]), 64'h0000);
    chk("a relu 7FFF", 64'(fmap_a[32 +: 16]), 64'h7FFF);
    chk("a relu 0000", 64'(fmap_a[48 +: 16]), 64'h0000);
    chk("a stale slot4", 64'(fmap_a[64 +: 16]), 64'h0005);
    for (int i = 4; i < 16; i++) send(1'b0, 16'h0040 + 16'(i), int'($urandom_range(0, 2)));
    in_data_a = 16'hDEAD;
    repeat (2) tick();
    chk("a out_valid held w/o ready", 64'(out_valid_a), 64'(1));
    out_ready_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    chk("a fill one cycle after ready", 64'(in_ready_a), 64'(1));

    // Reset mid-frame after 7 beats
    for (int i = 0; i < 7; i++) send(1'b0, 16'h0020 + 16'(i), 0);
    in_valid_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("midframe reset fmap zero", 64'(fmap_a == '0), 64'(1));
    chk("midframe reset in_ready", 64'(in_ready_a), 64'(1));
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 16'h0100 + 16'(i), 0);
      if (i == 0) chk("new frame slot0", 64'(fmap_a[0 +: 16]), 64'h0100);
      chk("a out_valid after new beats", 64'(out_valid_a), 64'(i == 15));
    end
    in_valid_a = 1'b0;
    tick();
    // Reset during hold drops out_valid without handshake
    reset = 1'b1;
    #1;
    chk("hold reset out_valid", 64'(out_valid_a), 64'(0));
    #1 reset = 1'b0;
    tick();

    // RELU=0 instance passes values unchanged
    for (int i = 0; i < 4; i++) send(1'b1, relu_in[i], 0);
    for (int i = 4; i < 8; i++) send(1'b1, 16'(i), 0);
    in_valid_b = 1'b0;
    chk("b pass 8000", 64'(fmap_b[0 +: 16]), 64'h8000);
    chk("b pass FFFF", 64'(fmap_b[16 +: 16]), 64'hFFFF);
    chk("b pass 7FFF", 64'(fmap_b[32 +: 16]), 64'h7FFF);
    chk("b pass 0000", 64'(fmap_b[48 +: 16]), 64'h0000);
    chk("b out_valid", 64'(out_valid_b), 64'(1));
    out_ready_b = 1'b1;
    tick();

    // Multi-channel ordering, two frames with out_ready tied high
    for (int i = 0; i < 8; i++) send(1'b1, 16'(i), 0);
    c1 = cyc;
    chk("b frame1 out_valid", 64'(out_valid_b), 64'(1));
    for (int k = 0; k < 8; k++) chk("b frame1 slot", 64'(fmap_b[k*16 +: 16]), 64'(k));
    for (int i = 8; i < 16; i++) send(1'b1, 16'(i), 0);
    c2 = cyc;
    in_valid_b = 1'b0;
    chk("b frame2 out_valid", 64'(out_valid_b), 64'(1));
    for (int k = 0; k < 8; k++) chk("b frame2 slot", 64'(fmap_b[k*16 +: 16]), 64'(k + 8));
    chk("b cycles per frame", 64'(c2 - c1), 64'(9));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
